// File: rtl/cmd_frame_gen.sv
// Host-side command framer: serialises one decoded command per handshake into
// the controller's byte frame (opcode first) over a byte-level valid/ready link.
module cmd_frame_gen #(
   parameter int GAP_CYCLES = 0,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_type,
   input  logic [3:0]       cmd_addr,
   input  logic [7:0]       cmd_data,
   input  logic [7:0]       cmd_a,
   input  logic [7:0]       cmd_b,
   input  logic [3:0]       cmd_fun,
   output logic [7:0]       byte_out,
   output logic             byte_valid,
   input  logic             byte_ready,
   output logic             frame_done,
   output logic [CNT_W-1:0] frame_cnt
);

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_DONE} state_t;
   typedef enum logic [1:0] {RF_WR = 2'd0, RF_RD = 2'd1, ALU_OP = 2'd2, ALU_NOP = 2'd3} cmd_t;

   localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

   state_t     state, state_nxt;
   cmd_t       type_q;
   logic [3:0] addr_q, fun_q;
   logic [7:0] data_q, a_q, b_q;
   logic [1:0] idx, last_idx;
   logic [7:0] gap_cnt, cur_byte;
   logic       accept, hs, last_byte;

   assign accept    = cmd_valid && cmd_ready;
   assign hs        = byte_valid && byte_ready;
   assign last_byte = (idx == last_idx);

   // Frame contents and length come only from the latched command, so the
   // pending byte cannot change while the sink stalls.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      cur_byte = 8'h00;
      last_idx = 2'd1;
      case (type_q)
         RF_WR: begin
            last_idx = 2'd2;
            case (idx)
               2'd0:    cur_byte = 8'hAA;
               2'd1:    cur_byte = {4'h0, addr_q};
               default: cur_byte = data_q;
            endcase
         end
         RF_RD: begin
            cur_byte = (idx == 2'd0) ? 8'hBB : {4'h0, addr_q};
         end
         ALU_OP: begin
            last_idx = 2'd3;
            case (idx)
               2'd0:    cur_byte = 8'hCC;
               2'd1:    cur_byte = a_q;
               2'd2:    cur_byte = b_q;
               default: cur_byte = {4'h0, fun_q};
            endcase
         end
         default: begin
            cur_byte = (idx == 2'd0) ? 8'hDD : {4'h0, fun_q};
         end
      endcase
   end

   always_comb begin
      state_nxt  = state;
      cmd_ready  = (state == ST_IDLE);
      byte_valid = (state == ST_SEND);
      frame_done = (state == ST_DONE);
      byte_out   = (state == ST_SEND) ? cur_byte : 8'h00;
      case (state)
         ST_IDLE: if (accept) state_nxt = ST_SEND;
         ST_SEND: begin
            if (hs) begin
               if (last_byte)           state_nxt = ST_DONE;
               else if (GAP_CYCLES > 0) state_nxt = ST_GAP;
            end
         end
         ST_GAP:  if (gap_cnt == GAP_LAST) state_nxt = ST_SEND;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         idx       <= 2'd0;
         gap_cnt   <= 8'd0;
         frame_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (accept)  idx <= 2'd0;
         else if (hs) idx <= idx + 2'd1;
         gap_cnt <= (state == ST_GAP) ? gap_cnt + 8'd1 : 8'd0;
         if (state == ST_DONE) frame_cnt <= frame_cnt + 1'b1;
      end
   end

   // NOTE: command fields are pure datapath; they are only observed in SEND
   // after an accept has loaded them, so they carry no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         type_q <= cmd_t'(cmd_type);
         addr_q <= cmd_addr;
         data_q <= cmd_data;
         a_q    <= cmd_a;
         b_q    <= cmd_b;
         fun_q  <= cmd_fun;
      end
   end

endmodule

// File: tb/tb_cmd_frame_gen.sv
// Self-checking bench for cmd_frame_gen: directed vector table, multi-cycle
// corner sequences and a randomized run against a byte-queue reference model.
module tb_cmd_frame_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, g_valid;
   logic [1:0] cmd_type;
   logic [3:0] cmd_addr, cmd_fun;
   logic [7:0] cmd_data, cmd_a, cmd_b;
   logic       byte_ready, g_ready;

   logic       cmd_ready, byte_valid, frame_done;
   logic [7:0] byte_out, frame_cnt;
   logic       g_cmd_ready, g_byte_valid, g_frame_done;
   logic [7:0] g_byte_out, g_frame_cnt;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_cnt;
   logic [7:0] q[$];

   typedef struct {
      logic [1:0]      typ;
      logic [3:0]      addr;
      logic [7:0]      data;
      logic [7:0]      a;
      logic [7:0]      b;
      logic [3:0]      fun;
      int              len;
      logic [3:0][7:0] exp_bytes;
   } vec_t;

   vec_t vecs[5];

   always #5 clk = ~clk;

   cmd_frame_gen #(.GAP_CYCLES(0), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun),
      .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .frame_done(frame_done), .frame_cnt(frame_cnt)
   );

   cmd_frame_gen #(.GAP_CYCLES(3), .CNT_W(8)) dut_gap (
      .clk(clk), .rst(rst), .cmd_valid(g_valid), .cmd_ready(g_cmd_ready),
      .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun),
      .byte_out(g_byte_out), .byte_valid(g_byte_valid), .byte_ready(g_ready),
      .frame_done(g_frame_done), .frame_cnt(g_frame_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic set_cmd(input logic [1:0] t, input logic [3:0] ad, input logic [7:0] d,
                          input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
      cmd_type = t; cmd_addr = ad; cmd_data = d; cmd_a = a; cmd_b = b; cmd_fun = f;
   endtask

   // Reference framing rules: expected byte list of one command.
   function automatic void push_frame(input logic [1:0] t, input logic [3:0] ad, input logic [7:0] d,
                                      input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
      case (t)
         2'd0: begin q.push_back(8'hAA); q.push_back({4'h0, ad}); q.push_back(d); end
         2'd1: begin q.push_back(8'hBB); q.push_back({4'h0, ad}); end
         2'd2: begin q.push_back(8'hCC); q.push_back(a); q.push_back(b); q.push_back({4'h0, f}); end
         default: begin q.push_back(8'hDD); q.push_back({4'h0, f}); end
      endcase
   endfunction

   // One frame on the GAP=0 instance with byte_ready high, cycle-exact.
   task automatic run_vec(input vec_t v, input string tag);
      @(negedge clk);
      check({tag, " ready_idle"}, cmd_ready, 1);
      set_cmd(v.typ, v.addr, v.data, v.a, v.b, v.fun);
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int k = 0; k < v.len; k++) begin
         check({tag, " valid"}, byte_valid, 1);
         check({tag, " byte"}, byte_out, v.exp_bytes[k]);
         check({tag, " busy"}, cmd_ready, 0);
         @(negedge clk);
      end
      check({tag, " done"}, frame_done, 1);
      check({tag, " valid_done"}, byte_valid, 0);
      exp_cnt++;
      @(negedge clk);
      check({tag, " ready_after"}, cmd_ready, 1);
      check({tag, " done_pulse"}, frame_done, 0);
      check({tag, " cnt"}, frame_cnt, exp_cnt);
   endtask

   initial begin
      int n;
      logic chk255, exp_done, cnt_pending, nxt_done, exp_ready;

      vecs[0] = '{typ:2'd0, addr:4'h5, data:8'h3C, a:8'h00, b:8'h00, fun:4'h0, len:3,
                  exp_bytes:{8'h00, 8'h3C, 8'h05, 8'hAA}};
      vecs[1] = '{typ:2'd2, addr:4'h0, data:8'h00, a:8'h12, b:8'h34, fun:4'h2, len:4,
                  exp_bytes:{8'h02, 8'h34, 8'h12, 8'hCC}};
      vecs[2] = '{typ:2'd1, addr:4'hF, data:8'h00, a:8'h00, b:8'h00, fun:4'h0, len:2,
                  exp_bytes:{8'h00, 8'h00, 8'h0F, 8'hBB}};
      vecs[3] = '{typ:2'd3, addr:4'h0, data:8'h00, a:8'h00, b:8'h00, fun:4'hA, len:2,
                  exp_bytes:{8'h00, 8'h00, 8'h0A, 8'hDD}};
      vecs[4] = '{typ:2'd0, addr:4'h0, data:8'hFF, a:8'h00, b:8'h00, fun:4'h0, len:3,
                  exp_bytes:{8'h00, 8'hFF, 8'h00, 8'hAA}};

      rst = 1'b1; cmd_valid = 1'b0; g_valid = 1'b0; byte_ready = 1'b1; g_ready = 1'b1;
      set_cmd(2'd0, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_cnt = 8'd0;

      // Reset state
      check("rst ready", cmd_ready, 1);
      check("rst valid", byte_valid, 0);
      check("rst byte", byte_out, 8'h00);
      check("rst done", frame_done, 0);
      check("rst cnt", frame_cnt, 0);
      check("rst gap ready", g_cmd_ready, 1);
      check("rst gap cnt", g_frame_cnt, 0);

      // Reset while third ALU_OP byte is pending aborts the frame
      set_cmd(2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h2);
      cmd_valid = 1'b1;
      @(negedge clk); cmd_valid = 1'b0;
      check("abort b0", byte_out, 8'hCC);
      @(negedge clk);
      check("abort b1", byte_out, 8'h12);
      @(negedge clk);
      check("abort b2", byte_out, 8'h34);
      byte_ready = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; byte_ready = 1'b1;
      check("abort valid", byte_valid, 0);
      check("abort ready", cmd_ready, 1);
      check("abort cnt", frame_cnt, exp_cnt);
      check("abort done", frame_done, 0);
      run_vec(vecs[2], "after_abort");

      // Directed vector table
      for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Stall on the second RF_WR byte
      @(negedge clk);
      set_cmd(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0);
      cmd_valid = 1'b1;
      @(negedge clk); cmd_valid = 1'b0;
      check("stall b0", byte_out, 8'hAA);
      @(negedge clk);
      check("stall b1", byte_out, 8'h05);
      byte_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall hold byte", byte_out, 8'h05);
         check("stall hold valid", byte_valid, 1);
         check("stall hold ready", cmd_ready, 0);
      end
      byte_ready = 1'b1;
      @(negedge clk);
      check("stall b2", byte_out, 8'h3C);
      @(negedge clk);
      check("stall done", frame_done, 1);
      exp_cnt++;
      @(negedge clk);
      check("stall cnt", frame_cnt, exp_cnt);

      // cmd_valid held high with changing fields during a frame
      set_cmd(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0);
      cmd_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k < 3) check("hold byte", byte_out, vecs[0].exp_bytes[k]);
         else       check("hold done", frame_done, 1);
         check("hold busy", cmd_ready, 0);
         set_cmd(2'($urandom_range(0, 3)), 4'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), 4'($urandom));
      end
      exp_cnt++;
      @(negedge clk);
      check("hold ready", cmd_ready, 1);
      set_cmd(2'd1, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0);
      @(negedge clk); cmd_valid = 1'b0;
      check("hold next b0", byte_out, 8'hBB);
      @(negedge clk);
      check("hold next b1", byte_out, 8'h03);
      @(negedge clk);
      exp_cnt++;
      @(negedge clk);
      check("hold next cnt", frame_cnt, exp_cnt);

      // Inter-byte gap on the GAP_CYCLES=3 instance
      set_cmd(2'd1, 4'hF, 8'h00, 8'h00, 8'h00, 4'h0);
      g_valid = 1'b1;
      @(negedge clk); g_valid = 1'b0;
      check("gap b0", g_byte_out, 8'hBB);
      check("gap b0 valid", g_byte_valid, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("gap idle", g_byte_valid, 0);
      end
      @(negedge clk);
      check("gap b1", g_byte_out, 8'h0F);
      check("gap b1 valid", g_byte_valid, 1);
      @(negedge clk);
      check("gap no trailing gap", g_frame_done, 1);
      @(negedge clk);
      check("gap ready", g_cmd_ready, 1);

      // 256 back-to-back frames wrap the 8-bit counter
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; exp_cnt = 8'd0;
      set_cmd(2'd1, 4'h1, 8'h00, 8'h00, 8'h00, 4'h0);
      cmd_valid = 1'b1;
      n = 0; chk255 = 1'b0;
      for (int cyc = 0; cyc < 3000 && n < 256; cyc++) begin
         @(negedge clk);
         if (chk255) begin
            check("wrap cnt 255", frame_cnt, 8'hFF);
            chk255 = 1'b0;
         end
         if (frame_done) begin
            n++;
            if (n == 255) chk255 = 1'b1;
            if (n == 256) cmd_valid = 1'b0;
         end
      end
      check("wrap frames", n, 256);
      @(negedge clk);
      check("wrap cnt 0", frame_cnt, 8'h00);

      // Randomized traffic against the byte-queue model
      q.delete();
      exp_done = 1'b0; cnt_pending = 1'b0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         exp_ready = (q.size() == 0) && !exp_done;
         check("rnd ready", cmd_ready, exp_ready);
         check("rnd valid", byte_valid, q.size() != 0);
         check("rnd done", frame_done, exp_done);
         if (q.size() != 0) check("rnd byte", byte_out, q[0]);
         if (cnt_pending) check("rnd cnt", frame_cnt, exp_cnt);
         cnt_pending = exp_done;
         if (exp_done) exp_cnt++;

         byte_ready = ($urandom_range(0, 3) != 0);
         cmd_valid  = $urandom_range(0, 1) == 1;
         set_cmd(2'($urandom_range(0, 3)), 4'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), 4'($urandom));
         nxt_done = 1'b0;
         if (q.size() != 0 && byte_ready) begin
            void'(q.pop_front());
            if (q.size() == 0) nxt_done = 1'b1;
         end
         if (cmd_valid && exp_ready) push_frame(cmd_type, cmd_addr, cmd_data, cmd_a, cmd_b, cmd_fun);
         exp_done = nxt_done;
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
